// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and the divider FSM state type.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/alu_divider_seq_if.sv
// Operand and result handshake bundle for the sequential divider.
interface alu_divider_seq_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_restore_step.sv
// One combinational restoring-division step: shift {R,Q} left, trial-subtract the divisor
// through a full-adder ripple, keep the difference when no borrow occurs.
module div_restore_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic [WIDTH-1:0] q_next
);

  // The bit shifted out of R becomes the top bit of the trial operand.
  logic [WIDTH:0]   r_shifted;
  logic [WIDTH:0]   b_inv;
  logic [WIDTH+1:0] carry;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  assign r_shifted = {r, q[WIDTH-1]};
  assign b_inv     = ~{1'b0, divisor};
  assign carry[0]  = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign carry[i+1] = (r_shifted[i] & b_inv[i]) | (carry[i] & (r_shifted[i] ^ b_inv[i]));
    if (i < WIDTH) begin : g_sum
      assign diff[i] = r_shifted[i] ^ b_inv[i] ^ carry[i];
    end
  end

  assign borrow = ~carry[WIDTH+1];
  assign r_next = borrow ? r_shifted[WIDTH-1:0] : diff;
  assign q_next = {q[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/alu_divider_seq.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, valid/ready on both
// the operand and result sides.
module alu_divider_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic               clk,
  input logic               rst,
  alu_divider_seq_if.slave  bus
);

  localparam int              CW         = $clog2(WIDTH);
  localparam logic [CW-1:0]   COUNT_LAST = CW'(WIDTH - 1);

  div_state_t       state;
  div_state_t       state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] div_reg;
  logic             dbz_reg;
  logic [WIDTH-1:0] r_step;
  logic [WIDTH-1:0] q_step;
  logic             accept;
  logic             handoff;
  logic             divisor_zero;

  assign bus.in_ready    = (state == DIV_IDLE);
  assign bus.out_valid   = (state == DIV_DONE);
  assign bus.quotient    = q_reg;
  assign bus.remainder   = r_reg;
  assign bus.div_by_zero = dbz_reg;

  assign accept       = bus.in_valid & bus.in_ready;
  assign handoff      = bus.out_valid & bus.out_ready;
  assign divisor_zero = (bus.divisor == '0);

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_reg),
    .q       (q_reg),
    .divisor (div_reg),
    .r_next  (r_step),
    .q_next  (q_step)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= DIV_IDLE;
    else     state <= state_next;
  end

  // NOTE: next-state gets its default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      DIV_IDLE: if (accept) state_next = divisor_zero ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (count == '0) state_next = DIV_DONE;
      DIV_DONE: if (handoff) state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // NOTE: the datapath registers are reset too, because the outputs are visible directly
  // and must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      r_reg   <= '0;
      q_reg   <= '0;
      div_reg <= '0;
      dbz_reg <= 1'b0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (accept) begin
            div_reg <= bus.divisor;
            count   <= COUNT_LAST;
            if (divisor_zero) begin
              q_reg   <= '1;
              r_reg   <= bus.dividend;
              dbz_reg <= 1'b1;
            end else begin
              q_reg   <= bus.dividend;
              r_reg   <= '0;
              dbz_reg <= 1'b0;
            end
          end
        end
        DIV_BUSY: begin
          r_reg <= r_step;
          q_reg <= q_step;
          if (count != '0) count <= count - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
